// File: rtl/ov5640_power_seq.sv
// ov5640_power_seq
//   Re-triggerable power sequencer for the OV5640 sensor. Follows the pwr_en
//   level request: walks PWDN/RESETB through the power-up order, raises
//   power_done once the sensor has settled, and powers down again (or aborts
//   a half-finished power-up) when pwr_en drops.
//
//   Optional feature macro: OV5640_POWER_SEQ_SHUTDOWN_EN
//     defined   : dropping pwr_en from SETTLE/ON first holds RESETB low with
//                 PWDN low for T_OFF_CYC cycles (SHUT), then raises PWDN.
//     undefined : dropping pwr_en from SETTLE/ON goes straight to OFF; the
//                 SHUT state and T_OFF_CYC do not exist.
//
//   Every timed phase lasts exactly T cycles: cnt clears on state entry and
//   the phase exits on the edge where cnt == T-1.
module ov5640_power_seq #(
  parameter int unsigned T_PWDN_CYC   = 300_000,
  parameter int unsigned T_RST_CYC    = 100_000,
  parameter int unsigned T_SETTLE_CYC = 1_050_000,
`ifdef OV5640_POWER_SEQ_SHUTDOWN_EN
  parameter int unsigned T_OFF_CYC    = 100_000,
`endif
  parameter int unsigned CNT_W        = 21
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic pwr_en,
  output logic ov5640_pwdn,
  output logic ov5640_resetb,
  output logic power_done,
  output logic seq_busy
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PWDN_WAIT = 3'd1,
    ST_RST_WAIT  = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_ON        = 3'd4
`ifdef OV5640_POWER_SEQ_SHUTDOWN_EN
    ,
    ST_SHUT      = 3'd5
`endif
  } state_t;

  // Terminal counts: the phase ends on the edge where cnt reaches T-1.
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(T_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE_CYC - 1);

  // Where a powered sensor goes when the request is withdrawn.
`ifdef OV5640_POWER_SEQ_SHUTDOWN_EN
  localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(T_OFF_CYC - 1);
  localparam state_t           DROP_STATE  = ST_SHUT;
`else
  localparam state_t           DROP_STATE  = ST_OFF;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwdn_q, pwdn_d;
  logic             resetb_q, resetb_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             timed_state;
  logic             phase_expired;

  // Classify the current state as timed and flag its final cycle.
  always_comb begin
    timed_state   = 1'b0;
    phase_expired = 1'b0;
    case (state_q)
      ST_PWDN_WAIT: begin
        timed_state   = 1'b1;
        phase_expired = (cnt_q == PWDN_LAST);
      end
      ST_RST_WAIT: begin
        timed_state   = 1'b1;
        phase_expired = (cnt_q == RST_LAST);
      end
      ST_SETTLE: begin
        timed_state   = 1'b1;
        phase_expired = (cnt_q == SETTLE_LAST);
      end
`ifdef OV5640_POWER_SEQ_SHUTDOWN_EN
      ST_SHUT: begin
        timed_state   = 1'b1;
        phase_expired = (cnt_q == OFF_LAST);
      end
`endif
      default: begin
        timed_state   = 1'b0;
        phase_expired = 1'b0;
      end
    endcase
  end

  // Next-state logic; a withdrawn request takes priority over phase expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (pwr_en) state_d = ST_PWDN_WAIT;
      end
      ST_PWDN_WAIT: begin
        if (!pwr_en)            state_d = ST_OFF;
        else if (phase_expired) state_d = ST_RST_WAIT;
      end
      ST_RST_WAIT: begin
        if (!pwr_en)            state_d = ST_OFF;
        else if (phase_expired) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!pwr_en)            state_d = DROP_STATE;
        else if (phase_expired) state_d = ST_ON;
      end
      ST_ON: begin
        if (!pwr_en)            state_d = DROP_STATE;
      end
`ifdef OV5640_POWER_SEQ_SHUTDOWN_EN
      // Shutdown always runs to completion regardless of pwr_en.
      ST_SHUT: begin
        if (phase_expired)      state_d = ST_OFF;
      end
`endif
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Phase counter: cleared on any state change, counts only in timed states.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && timed_state) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Output decode from the next state so outputs switch with the state register.
  always_comb begin
    pwdn_d   = 1'b1;
    resetb_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      ST_PWDN_WAIT: begin
        pwdn_d   = 1'b1;
        busy_d   = 1'b1;
      end
      ST_RST_WAIT: begin
        pwdn_d   = 1'b0;
        busy_d   = 1'b1;
      end
      ST_SETTLE: begin
        pwdn_d   = 1'b0;
        resetb_d = 1'b1;
        busy_d   = 1'b1;
      end
      ST_ON: begin
        pwdn_d   = 1'b0;
        resetb_d = 1'b1;
        done_d   = 1'b1;
      end
`ifdef OV5640_POWER_SEQ_SHUTDOWN_EN
      // Reset is asserted while supplies stay up, before power-down.
      ST_SHUT: begin
        pwdn_d   = 1'b0;
        resetb_d = 1'b0;
        busy_d   = 1'b1;
      end
`endif
      default: begin
        pwdn_d   = 1'b1;
        resetb_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset forces the sensor powered down.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      pwdn_q   <= 1'b1;
      resetb_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwdn_q   <= pwdn_d;
      resetb_q <= resetb_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ov5640_pwdn   = pwdn_q;
  assign ov5640_resetb = resetb_q;
  assign power_done    = done_q;
  assign seq_busy      = busy_q;

endmodule
